// File: rtl/fsic_axis_pkg.sv
// fsic_axis_pkg
// Shared AXI-Stream field widths and the packed-word layout used by the
// IO serdes receive FIFO. Fields are stored with tuser in the low bits:
//   {tupsb, tdata, tstrb, tkeep, tlast, tid, tuser}
// At the default widths (tdata 32, tupsb 5) the packed word is 50 bits.
// The layout helpers are functions of the data and sideband widths, so a
// parameterised FIFO stays consistent with the layout.
package fsic_axis_pkg;

    localparam int AXIS_DATA_W  = 32;
    localparam int AXIS_UPSB_W  = 5;
    localparam int AXIS_TLAST_W = 1;
    localparam int AXIS_TID_W   = 2;
    localparam int AXIS_TUSER_W = 2;

    localparam int OFF_TUSER = 0;
    localparam int OFF_TID   = OFF_TUSER + AXIS_TUSER_W;
    localparam int OFF_TLAST = OFF_TID + AXIS_TID_W;
    localparam int OFF_TKEEP = OFF_TLAST + AXIS_TLAST_W;

    // tstrb and tkeep carry one bit per data byte
    function automatic int axis_strb_w(input int data_w);
        return data_w / 32'sd8;
    endfunction

    function automatic int axis_off_tstrb(input int data_w);
        return OFF_TKEEP + axis_strb_w(data_w);
    endfunction

    function automatic int axis_off_tdata(input int data_w);
        return axis_off_tstrb(data_w) + axis_strb_w(data_w);
    endfunction

    function automatic int axis_off_tupsb(input int data_w);
        return axis_off_tdata(data_w) + data_w;
    endfunction

    function automatic int axis_word_w(input int data_w, input int upsb_w);
        return axis_off_tupsb(data_w) + upsb_w;
    endfunction

    localparam int AXIS_WORD_W = axis_word_w(AXIS_DATA_W, AXIS_UPSB_W);

endpackage

// File: rtl/fsic_sync_fifo_mem.sv
// fsic_sync_fifo_mem
// Storage array for a synchronous FIFO: one clocked write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk     : write clock (rising edge)
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data word
//   rd_addr : read address
//   rd_data : word currently stored at rd_addr
module fsic_sync_fifo_mem #(
    parameter int pWIDTH = 50,
    parameter int pDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(pDEPTH)-1:0] wr_addr,
    input  logic [pWIDTH-1:0]         wr_data,
    input  logic [$clog2(pDEPTH)-1:0] rd_addr,
    output logic [pWIDTH-1:0]         rd_data
);

    logic [pWIDTH-1:0] mem_r [pDEPTH];

    // Write port: store the incoming word when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fsic_is_rx_fifo.sv
// fsic_is_rx_fifo
// Receive FIFO between the IO serdes Rx path and a downstream AXI-Stream
// sink. The serdes cannot be back-pressured, so a beat arriving while the
// FIFO is full (and nothing leaves) is dropped and flagged on the sticky
// overflow bit. as_is_tready is returned to the remote transmitter and
// drops early enough (pTHRESHOLD free slots) to cover the round trip.
// The output is first-word-fall-through: m_* is the entry at the read
// pointer whenever m_tvalid is high.
// Ports:
//   axis_clk, axis_rst           : clock, async active-high reset
//   is_as_t*                     : beat received from the serdes
//   m_t*, m_tvalid, m_tready     : downstream AXI-Stream master
//   as_is_tready                 : registered flow-control bit to remote
//   fifo_count                   : current occupancy
//   overflow, clr_overflow       : sticky drop flag and its clear
module fsic_is_rx_fifo
    import fsic_axis_pkg::*;
#(
    parameter int pDATA_WIDTH                  = 32,
    parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
    parameter int pDEPTH                       = 8,
    parameter int pTHRESHOLD                   = 2
) (
    input  logic                                    axis_clk,
    input  logic                                    axis_rst,
    input  logic [pDATA_WIDTH-1:0]                  is_as_tdata,
    input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] is_as_tupsb,
    input  logic [pDATA_WIDTH/8-1:0]                is_as_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]                is_as_tkeep,
    input  logic                                    is_as_tlast,
    input  logic [1:0]                              is_as_tid,
    input  logic [1:0]                              is_as_tuser,
    input  logic                                    is_as_tvalid,
    output logic [pDATA_WIDTH-1:0]                  m_tdata,
    output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] m_tupsb,
    output logic [pDATA_WIDTH/8-1:0]                m_tstrb,
    output logic [pDATA_WIDTH/8-1:0]                m_tkeep,
    output logic                                    m_tlast,
    output logic [1:0]                              m_tid,
    output logic [1:0]                              m_tuser,
    output logic                                    m_tvalid,
    input  logic                                    m_tready,
    output logic                                    as_is_tready,
    output logic [$clog2(pDEPTH):0]                 fifo_count,
    output logic                                    overflow,
    input  logic                                    clr_overflow
);

    localparam int AW      = $clog2(pDEPTH);
    localparam int CW      = AW + 1;
    localparam int STRB_W  = axis_strb_w(pDATA_WIDTH);
    localparam int WORD_W  = axis_word_w(pDATA_WIDTH, pUSER_PROJECT_SIDEBAND_WIDTH);
    localparam int O_TSTRB = axis_off_tstrb(pDATA_WIDTH);
    localparam int O_TDATA = axis_off_tdata(pDATA_WIDTH);
    localparam int O_TUPSB = axis_off_tupsb(pDATA_WIDTH);

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              m_tvalid_r;
    logic              overflow_r;
    logic              as_is_tready_r;

    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [CW-1:0]     count_next_s;
    logic              tready_next_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;

    // Handshake decode: a full FIFO still takes a beat when one leaves
    always_comb begin
        pop_s         = m_tvalid_r & m_tready;
        full_s        = (count_r == CW'(pDEPTH));
        push_ok_s     = is_as_tvalid & (~full_s | pop_s);
        drop_s        = is_as_tvalid & full_s & ~pop_s;
        count_next_s  = count_r + CW'(push_ok_s) - CW'(pop_s);
        tready_next_s = ((CW'(pDEPTH) - count_next_s) > CW'(pTHRESHOLD));
    end

    // Pointer, occupancy, valid and flow-control state
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            m_tvalid_r     <= 1'b0;
            as_is_tready_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r        <= count_next_s;
            m_tvalid_r     <= (count_next_s != '0);
            as_is_tready_r <= tready_next_s;
        end
    end

    // Sticky overflow: a drop wins over a simultaneous clear
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_overflow) begin
            overflow_r <= 1'b0;
        end
    end

    assign wr_word_s = {is_as_tupsb, is_as_tdata, is_as_tstrb, is_as_tkeep,
                        is_as_tlast, is_as_tid, is_as_tuser};

    fsic_sync_fifo_mem #(
        .pWIDTH (WORD_W),
        .pDEPTH (pDEPTH)
    ) u_mem (
        .clk     (axis_clk),
        .wr_en   (push_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_word_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_word_s)
    );

    assign m_tuser      = rd_word_s[OFF_TUSER +: AXIS_TUSER_W];
    assign m_tid        = rd_word_s[OFF_TID +: AXIS_TID_W];
    assign m_tlast      = rd_word_s[OFF_TLAST];
    assign m_tkeep      = rd_word_s[OFF_TKEEP +: STRB_W];
    assign m_tstrb      = rd_word_s[O_TSTRB +: STRB_W];
    assign m_tdata      = rd_word_s[O_TDATA +: pDATA_WIDTH];
    assign m_tupsb      = rd_word_s[O_TUPSB +: pUSER_PROJECT_SIDEBAND_WIDTH];
    assign m_tvalid     = m_tvalid_r;
    assign fifo_count   = count_r;
    assign overflow     = overflow_r;
    assign as_is_tready = as_is_tready_r;

endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
// Testbench for fsic_is_rx_fifo (pDEPTH = 8, pTHRESHOLD = 2). A queue-based
// reference model tracks contents, overflow and the flow-control bit.
module tb_fsic_is_rx_fifo;

    localparam int DEPTH = 8;
    localparam int THR   = 2;
    localparam int W     = 50;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic [31:0] is_as_tdata = 32'd0;
    logic [4:0]  is_as_tupsb = 5'd0;
    logic [3:0]  is_as_tstrb = 4'd0;
    logic [3:0]  is_as_tkeep = 4'd0;
    logic        is_as_tlast = 1'b0;
    logic [1:0]  is_as_tid = 2'd0;
    logic [1:0]  is_as_tuser = 2'd0;
    logic        is_as_tvalid = 1'b0;
    logic [31:0] m_tdata;
    logic [4:0]  m_tupsb;
    logic [3:0]  m_tstrb;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic [1:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        as_is_tready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int checks = 0;
    int failures = 0;

    // reference model
    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;
    logic         m_rdy = 1'b0;

    fsic_is_rx_fifo #(
        .pDATA_WIDTH(32), .pUSER_PROJECT_SIDEBAND_WIDTH(5),
        .pDEPTH(DEPTH), .pTHRESHOLD(THR)
    ) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .is_as_tdata(is_as_tdata), .is_as_tupsb(is_as_tupsb), .is_as_tstrb(is_as_tstrb),
        .is_as_tkeep(is_as_tkeep), .is_as_tlast(is_as_tlast), .is_as_tid(is_as_tid),
        .is_as_tuser(is_as_tuser), .is_as_tvalid(is_as_tvalid),
        .m_tdata(m_tdata), .m_tupsb(m_tupsb), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .as_is_tready(as_is_tready), .fifo_count(fifo_count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 axis_clk = ~axis_clk;

    function automatic logic [W-1:0] in_word();
        return {is_as_tupsb, is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tlast, is_as_tid, is_as_tuser};
    endfunction

    function automatic logic [W-1:0] out_word();
        return {m_tupsb, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tuser};
    endfunction

    task automatic rand_beat();
        is_as_tdata = $urandom;
        is_as_tupsb = 5'($urandom);
        is_as_tstrb = 4'($urandom);
        is_as_tkeep = 4'($urandom);
        is_as_tlast = 1'($urandom);
        is_as_tid   = 2'($urandom);
        is_as_tuser = 2'($urandom);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_rdy = 1'b0;
    endtask

    // One clock edge with the current inputs; the model follows the rules:
    // pop when non-empty and ready, push unless full without a pop.
    task automatic tick();
        logic         pop;
        logic         full;
        logic [W-1:0] w;
        logic [W-1:0] gone;
        pop  = (mq.size() != 0) && m_tready;
        full = (mq.size() == DEPTH);
        w    = in_word();
        @(posedge axis_clk);
        if (pop) gone = mq.pop_front();
        if (is_as_tvalid && (!full || pop)) mq.push_back(w);
        if (is_as_tvalid && full && !pop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        m_rdy = ((DEPTH - mq.size()) > THR);
        #1;
    endtask

    task automatic test_reset();
        axis_rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if (m_tvalid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 || as_is_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b cnt=%0d ovf=%b rdy=%b expected 0/0/0/0", m_tvalid, fifo_count, overflow, as_is_tready);
        end
        @(negedge axis_clk);
        axis_rst = 1'b0;
        tick();
        checks++;
        if (as_is_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_tready: got %b expected 1", as_is_tready);
        end
    endtask

    task automatic test_three_pushes();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            is_as_tdata  = vals[i];
            is_as_tvalid = 1'b1;
            tick();
            if (i == 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 32'h11) begin
                    failures++;
                    $display("FAIL first_fall_through: got v=%b data=%0h expected 1/11", m_tvalid, m_tdata);
                end
            end
        end
        is_as_tvalid = 1'b0;
        checks++;
        if (fifo_count !== 4'd3 || as_is_tready !== 1'b1 || m_tdata !== 32'h11) begin
            failures++;
            $display("FAIL three_pushes: got cnt=%0d rdy=%b data=%0h expected 3/1/11", fifo_count, as_is_tready, m_tdata);
        end
    endtask

    task automatic test_fill_overflow();
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            is_as_tvalid = 1'b1;
            tick();
            checks++;
            if (fifo_count !== 4'(mq.size()) || as_is_tready !== m_rdy || overflow !== m_ovf) begin
                failures++;
                $display("FAIL fill_step%0d: got cnt=%0d rdy=%b ovf=%b expected %0d/%b/%b", i, fifo_count, as_is_tready, overflow, mq.size(), m_rdy, m_ovf);
            end
            if (mq.size() == 5 || mq.size() == 6) begin
                checks++;
                if (as_is_tready !== (mq.size() == 5)) begin
                    failures++;
                    $display("FAIL tready_threshold: cnt=%0d got %b expected %b", mq.size(), as_is_tready, mq.size() == 5);
                end
            end
        end
        is_as_tvalid = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || m_tdata !== 32'h11 || as_is_tready !== 1'b0) begin
            failures++;
            $display("FAIL ninth_push_drop: got cnt=%0d ovf=%b data=%0h rdy=%b expected 8/1/11/0", fifo_count, overflow, m_tdata, as_is_tready);
        end
    endtask

    task automatic test_overflow_clear();
        rand_beat();
        is_as_tvalid = 1'b1;
        clr_overflow = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8 || out_word() !== mq[0]) begin
            failures++;
            $display("FAIL clr_with_drop: got ovf=%b cnt=%0d expected 1/8", overflow, fifo_count);
        end
        is_as_tvalid = 1'b0;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] tail;
        rand_beat();
        tail = in_word();
        is_as_tvalid = 1'b1;
        m_tready = 1'b1;
        tick();
        is_as_tvalid = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0 || m_tdata !== 32'h22) begin
            failures++;
            $display("FAIL full_push_pop: got cnt=%0d ovf=%b data=%0h expected 8/0/22", fifo_count, overflow, m_tdata);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || out_word() !== mq[0]) begin
                failures++;
                $display("FAIL drain_order%0d: got %0h expected %0h", i, out_word(), mq[0]);
            end
            if (i == DEPTH - 1) begin
                checks++;
                if (out_word() !== tail) begin
                    failures++;
                    $display("FAIL drain_tail: got %0h expected %0h", out_word(), tail);
                end
            end
            tick();
        end
        m_tready = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || fifo_count !== 4'd0 || as_is_tready !== 1'b1) begin
            failures++;
            $display("FAIL drained_empty: got v=%b cnt=%0d rdy=%b expected 0/0/1", m_tvalid, fifo_count, as_is_tready);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int popped = 0;
        for (int c = 0; c < 60 && (sent < 20 || mq.size() != 0); c++) begin
            is_as_tvalid = (sent < 20) && (c % 3 != 2);
            if (is_as_tvalid) begin
                rand_beat();
                is_as_tlast = (sent % 4 == 3);
                sent++;
            end
            m_tready = (c < 30) ? ((c % 2) == 0) : 1'b1;
            checks++;
            if (m_tvalid !== (mq.size() != 0) || (mq.size() != 0 && out_word() !== mq[0])) begin
                failures++;
                $display("FAIL stream_c%0d: got v=%b word=%0h expected v=%b", c, m_tvalid, out_word(), mq.size() != 0);
            end
            if (m_tvalid && m_tready) popped++;
            tick();
        end
        is_as_tvalid = 1'b0;
        m_tready = 1'b0;
        checks++;
        if (popped != 20 || overflow !== 1'b0 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL stream_total: got popped=%0d ovf=%b cnt=%0d expected 20/0/0", popped, overflow, fifo_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rand_beat();
            is_as_tvalid = ($urandom_range(0, 99) < 60);
            m_tready     = ($urandom_range(0, 99) < 45);
            clr_overflow = ($urandom_range(0, 99) < 8);
            tick();
            checks++;
            if (fifo_count !== 4'(mq.size()) || m_tvalid !== (mq.size() != 0) ||
                overflow !== m_ovf || as_is_tready !== m_rdy ||
                (mq.size() != 0 && out_word() !== mq[0])) begin
                failures++;
                $display("FAIL random_c%0d: got cnt=%0d v=%b ovf=%b rdy=%b word=%0h expected %0d/%b/%b", c, fifo_count, m_tvalid, overflow, as_is_tready, out_word(), mq.size(), m_ovf, m_rdy);
            end
        end
        is_as_tvalid = 1'b0;
        m_tready = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic test_async_reset();
        while (mq.size() > 5) begin
            m_tready = 1'b1;
            tick();
        end
        m_tready = 1'b0;
        while (mq.size() < 5) begin
            rand_beat();
            is_as_tvalid = 1'b1;
            tick();
        end
        is_as_tvalid = 1'b0;
        checks++;
        if (fifo_count !== 4'd5) begin
            failures++;
            $display("FAIL async_pre_count: got %0d expected 5", fifo_count);
        end
        #2;
        axis_rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || fifo_count !== 4'd0 || as_is_tready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b expected 0/0/0", m_tvalid, fifo_count, as_is_tready);
        end
        @(negedge axis_clk);
        axis_rst = 1'b0;
        tick();
        checks++;
        if (as_is_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL async_release: got rdy=%b v=%b expected 1/0", as_is_tready, m_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_three_pushes();
        test_fill_overflow();
        test_overflow_clear();
        test_full_push_pop();
        test_stream();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsic_is_rx_fifo.md
FSIC_IS_RX_FIFO -- requirements
Module: fsic_is_rx_fifo

Interface
REQ-001 Parameter pDATA_WIDTH, default 32: tdata width in bits.
REQ-002 Parameter pUSER_PROJECT_SIDEBAND_WIDTH, default 5: tupsb width in bits.
REQ-003 Parameter pDEPTH, default 8: FIFO entries; a power of two, minimum 4.
REQ-004 Parameter pTHRESHOLD, default 2: free-slot margin that covers remote round-trip latency; less than pDEPTH.
REQ-005 axis_clk  in  1: the only clock; every flop is clocked on its rising edge.
REQ-006 axis_rst  in  1: reset, asynchronous assert, active-high.
REQ-007 is_as_tdata/tupsb/tstrb/tkeep/tlast/tid/tuser  in  32/5/4/4/1/2/2: received beat from the IO serdes Rx path.
REQ-008 is_as_tvalid  in  1: a received beat is present; there is no back-pressure toward the serdes.
REQ-009 m_tdata/tupsb/tstrb/tkeep/tlast/tid/tuser  out  same widths: head-of-FIFO beat.
REQ-010 m_tvalid  out  1; m_tready  in  1: downstream AXI-Stream handshake.
REQ-011 as_is_tready  out  1: flow-control bit fed to the local serdes Tx path and forwarded to the remote side.
REQ-012 fifo_count  out  clog2(pDEPTH)+1: current occupancy.
REQ-013 overflow  out  1: sticky drop flag; clr_overflow  in  1: synchronous clear.

Function
REQ-014 push = is_as_tvalid; pop = m_tvalid & m_tready.
REQ-015 A push SHALL be accepted when count < pDEPTH, or when count == pDEPTH and a pop occurs in the same cycle.
REQ-016 A push with count == pDEPTH and no pop SHALL be dropped and SHALL set overflow = 1 on the next edge; FIFO contents and pointers SHALL remain unchanged.
REQ-017 clr_overflow SHALL clear overflow on the next edge; a simultaneous drop SHALL take priority and leave overflow = 1.
REQ-018 The FIFO SHALL be first-word-fall-through: m_tvalid = (count != 0), and m_* SHALL equal the entry at rd_ptr.
REQ-019 Latency: a beat pushed into an empty FIFO at edge N SHALL appear with m_tvalid = 1 after edge N.
REQ-020 m_* SHALL hold stable while m_tvalid = 1 and m_tready = 0.
REQ-021 Pointers are clog2(pDEPTH) bits wide and SHALL wrap from pDEPTH-1 to 0.
REQ-022 count_next = count + accepted_push - pop, evaluated with a simultaneous push and pop.
REQ-023 A pop on an empty FIFO cannot occur, because m_tvalid = 0.
REQ-024 as_is_tready SHALL be registered: as_is_tready <= (pDEPTH - count_next) > pTHRESHOLD.
REQ-025 All fields, including tlast/tid/tuser/tupsb, SHALL be stored as one packed word and SHALL NOT be interpreted.

Reset
REQ-026 On axis_rst: count = 0, rd_ptr = 0, wr_ptr = 0, m_tvalid = 0, overflow = 0, as_is_tready = 0.
REQ-027 Storage contents are not reset; m_* data is don't-care while m_tvalid = 0.
REQ-028 as_is_tready SHALL rise on the first edge after reset deassertion.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-030 Package fsic_axis_pkg SHALL hold the field widths, the packed-word width (50 at defaults), and the pack/unpack field offsets.
REQ-031 Storage SHALL be the sub-module fsic_sync_fifo_mem: 1 write port, 1 asynchronous read port, no reset.
REQ-032 Pointer, count, flow-control and overflow logic SHALL stay in fsic_is_rx_fifo.

Verification (pDEPTH = 8, pTHRESHOLD = 2)
REQ-033 Reset, then 3 pushes with tdata 0x11, 0x22, 0x33 and m_tready = 0 -> fifo_count = 3; m_tdata = 0x11 one cycle after the first push; as_is_tready = 1.
REQ-034 Continuous push with m_tready = 0 -> as_is_tready falls on the edge where count_next reaches 6; the 9th push is dropped, overflow = 1, count stays 8.
REQ-035 Full FIFO, push and pop in the same cycle -> both accepted; count stays 8; overflow stays 0; output order is preserved.
REQ-036 Stream 20 beats with tlast on every 4th beat and m_tready toggling 1/0 -> output order, tlast/tid/tuser/tupsb match input; pointers wrap with no loss.
REQ-037 Reset asserted with count = 5 -> m_tvalid = 0, count = 0 and as_is_tready = 0 asynchronously; as_is_tready = 1 on the first edge after release.
REQ-038 overflow = 1, clr_overflow pulsed together with a drop -> overflow stays 1; clr_overflow pulsed alone -> overflow = 0.
